// File: rtl/lfsr_pkg.sv
// Shared opcodes, FSM state encoding and strobe bundle for the LFSR
// pattern-generator instruction sequencer.
package lfsr_pkg;

    localparam int INSTR_W = 14;
    localparam int PC_W    = 8;

    localparam logic [5:0] OP_CFG       = 6'b000001;
    localparam logic [5:0] OP_INIT_L    = 6'b000010;
    localparam logic [5:0] OP_STEP      = 6'b000011;
    localparam logic [5:0] OP_STORE     = 6'b000100;
    localparam logic [5:0] OP_LOAD      = 6'b000101;
    localparam logic [5:0] OP_INIT_ADDR = 6'b000110;
    localparam logic [5:0] OP_ADD_ADDR  = 6'b000111;
    localparam logic [5:0] OP_RUN_N     = 6'b001000;
    localparam logic [5:0] OP_HD_STORE  = 6'b001001;
    localparam logic [5:0] OP_HALT      = 6'b111111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_B_STEP,
        ST_B_STORE,
        ST_HALT,
        ST_ERR
    } state_t;

    typedef struct packed {
        logic tap_we;
        logic seed_we;
        logic step;
        logic addr_init;
        logic addr_add;
        logic addr_inc;
        logic store_we;
        logic load_we;
        logic hd_store_we;
    } strobe_t;

endpackage

// File: rtl/lfsr_decode.sv
// Combinational opcode decoder: one-hot datapath strobes plus the
// classification flags the sequencer FSM branches on.
module lfsr_decode
    import lfsr_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic       shamt,
    output strobe_t    strb,
    output logic       is_illegal,
    output logic       is_halt,
    output logic       is_burst
);

    always_comb begin
        strb       = '0;
        is_illegal = 1'b0;
        is_halt    = 1'b0;
        is_burst   = 1'b0;
        unique case (opcode)
            // The tap register is only 7 bits wide, so a set shamt bit is rejected.
            OP_CFG: begin
                if (shamt) begin
                    is_illegal = 1'b1;
                end else begin
                    strb.tap_we = 1'b1;
                end
            end
            OP_INIT_L:    strb.seed_we     = 1'b1;
            OP_STEP:      strb.step        = 1'b1;
            OP_STORE:     strb.store_we    = 1'b1;
            OP_LOAD:      strb.load_we     = 1'b1;
            OP_INIT_ADDR: strb.addr_init   = 1'b1;
            OP_ADD_ADDR:  strb.addr_add    = 1'b1;
            OP_HD_STORE:  strb.hd_store_we = 1'b1;
            OP_RUN_N:     is_burst         = 1'b1;
            OP_HALT:      is_halt          = 1'b1;
            default:      is_illegal       = 1'b1;
        endcase
    end

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Instruction sequencer for the LFSR pattern generator: fetches from ROM,
// decodes into one-cycle datapath strobes and runs RUN_STORE_N bursts.
module lfsr_seq_ctrl
    import lfsr_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc,
    output logic [7:0]         operand,
    output logic               tap_we,
    output logic               seed_we,
    output logic               step,
    output logic               addr_init,
    output logic               addr_add,
    output logic               addr_inc,
    output logic               store_we,
    output logic               load_we,
    output logic               hd_store_we,
    output logic               busy,
    output logic               halted,
    output logic               err
);

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [7:0]         cnt_q, cnt_d;

    strobe_t dec_strb;
    strobe_t strb;
    logic    is_illegal;
    logic    is_halt;
    logic    is_burst;
    logic [7:0] ir_operand;

    assign ir_operand = ir_q[7:0];

    lfsr_decode u_decode (
        .opcode     (ir_q[13:8]),
        .shamt      (ir_q[7]),
        .strb       (dec_strb),
        .is_illegal (is_illegal),
        .is_halt    (is_halt),
        .is_burst   (is_burst)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        if (abort) begin
            state_d = ST_IDLE;
            pc_d    = '0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_HALT, ST_ERR: begin
                    if (start) begin
                        state_d = ST_FETCH;
                        pc_d    = '0;
                    end
                end
                ST_FETCH: begin
                    ir_d    = instr;
                    state_d = ST_EXEC;
                end
                ST_EXEC: begin
                    // HALT and illegal opcodes leave pc pointing at themselves.
                    if (is_illegal) begin
                        state_d = ST_ERR;
                    end else if (is_halt) begin
                        state_d = ST_HALT;
                    end else if (is_burst && ir_operand != 8'd0) begin
                        cnt_d   = ir_operand;
                        state_d = ST_B_STEP;
                    end else begin
                        pc_d    = pc_q + 1'b1;
                        state_d = ST_FETCH;
                    end
                end
                ST_B_STEP: begin
                    state_d = ST_B_STORE;
                end
                ST_B_STORE: begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        pc_d    = pc_q + 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_B_STEP;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
        end
    end

    // Strobes depend only on registered state; abort masks them so nothing
    // reaches the datapath in the cycle the sequencer is being torn down.
    always_comb begin
        strb = '0;
        if (!abort) begin
            unique case (state_q)
                ST_EXEC:    strb = dec_strb;
                ST_B_STEP:  strb.step = 1'b1;
                ST_B_STORE: begin
                    strb.store_we = 1'b1;
                    strb.addr_inc = 1'b1;
                end
                default:    strb = '0;
            endcase
        end
    end

    assign tap_we      = strb.tap_we;
    assign seed_we     = strb.seed_we;
    assign step        = strb.step;
    assign addr_init   = strb.addr_init;
    assign addr_add    = strb.addr_add;
    assign addr_inc    = strb.addr_inc;
    assign store_we    = strb.store_we;
    assign load_we     = strb.load_we;
    assign hd_store_we = strb.hd_store_we;

    assign pc      = pc_q;
    assign operand = ir_operand;
    assign busy    = (state_q == ST_FETCH) || (state_q == ST_EXEC) ||
                     (state_q == ST_B_STEP) || (state_q == ST_B_STORE);
    assign halted  = (state_q == ST_HALT);
    assign err     = (state_q == ST_ERR);

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Directed bench for lfsr_seq_ctrl driving a behavioural instruction ROM.
module tb_lfsr_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [13:0] instr;
    logic [7:0]  pc;
    logic [7:0]  operand;
    logic        tap_we, seed_we, step, addr_init, addr_add, addr_inc;
    logic        store_we, load_we, hd_store_we;
    logic        busy, halted, err;

    logic [13:0] rom [256];

    int checks = 0;
    int errors = 0;

    lfsr_seq_ctrl #(.PC_W(8), .INSTR_W(14)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .instr       (instr),
        .pc          (pc),
        .operand     (operand),
        .tap_we      (tap_we),
        .seed_we     (seed_we),
        .step        (step),
        .addr_init   (addr_init),
        .addr_add    (addr_add),
        .addr_inc    (addr_inc),
        .store_we    (store_we),
        .load_we     (load_we),
        .hd_store_we (hd_store_we),
        .busy        (busy),
        .halted      (halted),
        .err         (err)
    );

    assign instr = rom[pc];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {tap, seed, step, addr_init, addr_add, addr_inc, store, load, hd}
    function automatic logic [8:0] strobes();
        return {tap_we, seed_we, step, addr_init, addr_add, addr_inc,
                store_we, load_we, hd_store_we};
    endfunction

    function automatic logic [11:0] outs();
        return {strobes(), busy, halted, err};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rom_fill(input logic [13:0] v);
        for (int i = 0; i < 256; i++) rom[i] = v;
    endtask

    task automatic go_idle();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        checks++;
        if (outs() !== 12'h000 || pc !== 8'h00 || operand !== 8'h00) begin
            errors++;
            $display("FAIL reset outs=%h pc=%h op=%h, required 000/00/00", outs(), pc, operand);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_program();
        logic [8:0] exp;
        logic [7:0] exp_op;
        go_idle();
        rom_fill(14'h3F00);
        rom[0] = 14'h0125;
        rom[1] = 14'h0255;
        rom[2] = 14'h0605;
        rom[3] = 14'h0300;
        rom[4] = 14'h0400;
        rom[5] = 14'h3F00;
        do_start();
        for (int t = 1; t <= 12; t++) begin
            tick();
            exp_op = 8'h00;
            case (t)
                1:       begin exp = 9'h100; exp_op = 8'h25; end
                3:       begin exp = 9'h080; exp_op = 8'h55; end
                5:       begin exp = 9'h020; exp_op = 8'h05; end
                7:       exp = 9'h040;
                9:       exp = 9'h004;
                default: exp = 9'h000;
            endcase
            checks++;
            if (strobes() !== exp) begin
                errors++;
                $display("FAIL prog_strobe t=%0d got %h required %h", t, strobes(), exp);
            end
            if (t == 1 || t == 3 || t == 5) begin
                checks++;
                if (operand !== exp_op) begin
                    errors++;
                    $display("FAIL prog_operand t=%0d got %h required %h", t, operand, exp_op);
                end
            end
        end
        checks++;
        if (halted !== 1'b1 || busy !== 1'b0 || pc !== 8'd5) begin
            errors++;
            $display("FAIL prog_halt halted=%b busy=%b pc=%0d, required 1/0/5", halted, busy, pc);
        end
        tick();
        checks++;
        if (halted !== 1'b1 || pc !== 8'd5) begin
            errors++;
            $display("FAIL prog_halt_hold halted=%b pc=%0d, required 1/5", halted, pc);
        end
    endtask

    task automatic test_misc_ops();
        logic [8:0] exp;
        go_idle();
        rom_fill(14'h3F00);
        rom[0] = 14'h0500;
        rom[1] = 14'h0703;
        rom[2] = 14'h0900;
        do_start();
        for (int t = 1; t <= 8; t++) begin
            tick();
            case (t)
                1:       exp = 9'h002;
                3:       exp = 9'h010;
                5:       exp = 9'h001;
                default: exp = 9'h000;
            endcase
            checks++;
            if (strobes() !== exp) begin
                errors++;
                $display("FAIL misc_strobe t=%0d got %h required %h", t, strobes(), exp);
            end
        end
        checks++;
        if (halted !== 1'b1 || pc !== 8'd3) begin
            errors++;
            $display("FAIL misc_halt halted=%b pc=%0d, required 1/3", halted, pc);
        end
    endtask

    task automatic test_burst();
        logic [8:0] exp;
        int busy_cnt;
        go_idle();
        rom_fill(14'h3F00);
        rom[0] = 14'h0803;
        do_start();
        busy_cnt = busy ? 1 : 0;
        for (int t = 1; t <= 7; t++) begin
            tick();
            if (busy) busy_cnt++;
            if (t == 1)          exp = 9'h000;
            else if (t % 2 == 0) exp = 9'h040;
            else                 exp = 9'h00C;
            checks++;
            if (strobes() !== exp) begin
                errors++;
                $display("FAIL burst_strobe t=%0d got %h required %h", t, strobes(), exp);
            end
        end
        checks++;
        if (busy_cnt != 8) begin
            errors++;
            $display("FAIL burst_busy_cycles got %0d required 8", busy_cnt);
        end
        tick();
        checks++;
        if (pc !== 8'd1 || busy !== 1'b1 || strobes() !== 9'h000) begin
            errors++;
            $display("FAIL burst_next_fetch pc=%0d busy=%b strb=%h, required 1/1/000", pc, busy, strobes());
        end
        repeat (2) tick();
        checks++;
        if (halted !== 1'b1 || pc !== 8'd1) begin
            errors++;
            $display("FAIL burst_halt halted=%b pc=%0d, required 1/1", halted, pc);
        end
    endtask

    task automatic test_burst_zero();
        go_idle();
        rom_fill(14'h3F00);
        rom[0] = 14'h0800;
        do_start();
        tick();
        checks++;
        if (strobes() !== 9'h000 || busy !== 1'b1 || pc !== 8'd0) begin
            errors++;
            $display("FAIL burst0_exec strb=%h busy=%b pc=%0d, required 000/1/0", strobes(), busy, pc);
        end
        tick();
        checks++;
        if (strobes() !== 9'h000 || busy !== 1'b1 || pc !== 8'd1) begin
            errors++;
            $display("FAIL burst0_fetch strb=%h busy=%b pc=%0d, required 000/1/1", strobes(), busy, pc);
        end
        repeat (2) tick();
        checks++;
        if (halted !== 1'b1 || pc !== 8'd1) begin
            errors++;
            $display("FAIL burst0_halt halted=%b pc=%0d, required 1/1", halted, pc);
        end
    endtask

    task automatic test_illegal();
        go_idle();
        rom_fill(14'h3F00);
        rom[0] = 14'h0300;
        rom[1] = 14'h0180;
        do_start();
        repeat (3) tick();
        checks++;
        if (strobes() !== 9'h000 || pc !== 8'd1) begin
            errors++;
            $display("FAIL illegal_cfg_exec strb=%h pc=%0d, required 000/1", strobes(), pc);
        end
        repeat (2) tick();
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || pc !== 8'd1 || strobes() !== 9'h000) begin
            errors++;
            $display("FAIL illegal_cfg_err err=%b busy=%b pc=%0d strb=%h, required 1/0/1/000", err, busy, pc, strobes());
        end

        rom[0] = 14'h0300;
        rom[1] = 14'h0300;
        rom[2] = 14'h1000;
        do_start();
        checks++;
        if (busy !== 1'b1 || err !== 1'b0 || pc !== 8'd0) begin
            errors++;
            $display("FAIL err_restart busy=%b err=%b pc=%0d, required 1/0/0", busy, err, pc);
        end
        repeat (7) tick();
        checks++;
        if (err !== 1'b1 || pc !== 8'd2 || strobes() !== 9'h000) begin
            errors++;
            $display("FAIL illegal_op_err err=%b pc=%0d strb=%h, required 1/2/000", err, pc, strobes());
        end
    endtask

    task automatic test_abort();
        go_idle();
        rom_fill(14'h3F00);
        rom[0] = 14'h0300;
        rom[1] = 14'h080A;
        do_start();
        repeat (6) tick();
        checks++;
        if (strobes() !== 9'h040 || pc !== 8'd1) begin
            errors++;
            $display("FAIL abort_pre strb=%h pc=%0d, required 040/1", strobes(), pc);
        end
        abort = 1'b1;
        #1;
        checks++;
        if (strobes() !== 9'h000) begin
            errors++;
            $display("FAIL abort_cycle_strobe got %h required 000", strobes());
        end
        tick();
        abort = 1'b0;
        #1;
        checks++;
        if (outs() !== 12'h000 || pc !== 8'd0) begin
            errors++;
            $display("FAIL abort_idle outs=%h pc=%0d, required 000/0", outs(), pc);
        end
        tick();
        checks++;
        if (store_we !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_store store=%b busy=%b, required 0/0", store_we, busy);
        end
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || halted !== 1'b0 || err !== 1'b0 || pc !== 8'd0) begin
            errors++;
            $display("FAIL start_abort_idle busy=%b halted=%b err=%b pc=%0d, required 0/0/0/0", busy, halted, err, pc);
        end
    endtask

    task automatic test_async_rst();
        go_idle();
        rom_fill(14'h3F00);
        rom[0] = 14'h0300;
        rom[1] = 14'h0277;
        do_start();
        repeat (3) tick();
        checks++;
        if (seed_we !== 1'b1 || operand !== 8'h77 || pc !== 8'd1) begin
            errors++;
            $display("FAIL rst_pre seed=%b op=%h pc=%0d, required 1/77/1", seed_we, operand, pc);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (outs() !== 12'h000 || pc !== 8'd0 || operand !== 8'h00) begin
            errors++;
            $display("FAIL async_rst outs=%h pc=%0d op=%h, required 000/0/00", outs(), pc, operand);
        end
        #2 rst = 1'b0;
        tick();
        checks++;
        if (outs() !== 12'h000 || pc !== 8'd0) begin
            errors++;
            $display("FAIL rst_release outs=%h pc=%0d, required 000/0", outs(), pc);
        end
    endtask

    task automatic test_start_busy();
        go_idle();
        rom_fill(14'h3F00);
        rom[0] = 14'h0300;
        rom[1] = 14'h0300;
        rom[2] = 14'h0300;
        do_start();
        repeat (2) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (pc !== 8'd1 || step !== 1'b1) begin
            errors++;
            $display("FAIL start_busy pc=%0d step=%b, required 1/1", pc, step);
        end
        tick();
        checks++;
        if (pc !== 8'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_busy_next pc=%0d busy=%b, required 2/1", pc, busy);
        end
    endtask

    task automatic test_wrap();
        int steps;
        go_idle();
        rom_fill(14'h0300);
        do_start();
        steps = 0;
        for (int t = 1; t <= 520; t++) begin
            tick();
            if (step) steps++;
            if (t == 510) begin
                checks++;
                if (pc !== 8'd255) begin
                    errors++;
                    $display("FAIL wrap_pc255 got %0d required 255", pc);
                end
            end
            if (t == 512) begin
                checks++;
                if (pc !== 8'd0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL wrap_pc0 pc=%0d busy=%b, required 0/1", pc, busy);
                end
            end
        end
        checks++;
        if (steps != 260) begin
            errors++;
            $display("FAIL wrap_steps got %0d required 260", steps);
        end
        go_idle();
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        rom_fill(14'h3F00);
        test_reset();
        test_program();
        test_misc_ops();
        test_burst();
        test_burst_zero();
        test_illegal();
        test_abort();
        test_async_rst();
        test_start_busy();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
